// File: rtl/baw_frame_writer_if.sv
// Bus between the black/white pixel source, the frame writer and the pixel sink.
// Ports (signals):
//   ready_signal, black_white_0, black_white_x : pixel-pair input from conversion stage
//   out_ready                                  : sink accepts out_pixel
//   out_valid, out_pixel, out_last             : pixel stream to sink
//   frame_done, busy, overflow                 : status
// master = source/sink side (drives inputs), slave = frame writer.
interface baw_frame_writer_if #(
  parameter int width_RGB = 8
);
  logic                 ready_signal;
  logic [width_RGB-1:0] black_white_0;
  logic [width_RGB-1:0] black_white_x;
  logic                 out_ready;
  logic                 out_valid;
  logic [width_RGB-1:0] out_pixel;
  logic                 out_last;
  logic                 frame_done;
  logic                 busy;
  logic                 overflow;

  modport master (
    output ready_signal, black_white_0, black_white_x, out_ready,
    input  out_valid, out_pixel, out_last, frame_done, busy, overflow
  );

  modport slave (
    input  ready_signal, black_white_0, black_white_x, out_ready,
    output out_valid, out_pixel, out_last, frame_done, busy, overflow
  );
endinterface

// File: rtl/baw_frame_writer.sv
// Captures black/white pixel pairs into an IMG_W x IMG_H raster buffer (FILL),
// then streams the complete frame out one pixel per valid/ready beat (DRAIN).
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (abandons any frame in progress)
//   bus  : baw_frame_writer_if.slave -- pixel-pair input, pixel stream output, status
module baw_frame_writer #(
  parameter int width_RGB = 8,
  parameter int IMG_W     = 32,
  parameter int IMG_H     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  baw_frame_writer_if.slave    bus
);
  localparam int N  = IMG_W * IMG_H;
  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST_PAIR = AW'(N - 2);
  localparam logic [AW-1:0] LAST_PIX  = AW'(N - 1);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t               state, state_next;
  logic [AW-1:0]        wr_ptr, wr_ptr_next;
  logic [AW-1:0]        rd_ptr, rd_ptr_next;
  logic                 frame_done_q, frame_done_next;
  logic                 overflow_q, overflow_next;
  logic                 wr_en;
  logic [AW-1:0]        wr_ptr_odd;
  logic [width_RGB-1:0] mem [N];

  // wr_ptr is always even, so the partner address is just its LSB set.
  assign wr_ptr_odd = {wr_ptr[AW-1:1], 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FILL;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state        <= state_next;
      wr_ptr       <= wr_ptr_next;
      rd_ptr       <= rd_ptr_next;
      frame_done_q <= frame_done_next;
      overflow_q   <= overflow_next;
    end
  end

  // Buffer contents survive reset; only the write is suppressed.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wr_ptr]     <= bus.black_white_0;
      mem[wr_ptr_odd] <= bus.black_white_x;
    end
  end

  always_comb begin
    state_next      = state;
    wr_ptr_next     = wr_ptr;
    rd_ptr_next     = rd_ptr;
    frame_done_next = 1'b0;
    overflow_next   = overflow_q;
    wr_en           = 1'b0;
    case (state)
      FILL: begin
        if (bus.ready_signal) begin
          wr_en = 1'b1;
          if (wr_ptr == LAST_PAIR) begin
            wr_ptr_next     = '0;
            state_next      = DRAIN;
            frame_done_next = 1'b1;
          end else begin
            wr_ptr_next = wr_ptr + AW'(2);
          end
        end
      end
      DRAIN: begin
        // No double buffer: a pair arriving now has nowhere to go.
        if (bus.ready_signal) overflow_next = 1'b1;
        if (bus.out_ready) begin
          if (rd_ptr == LAST_PIX) begin
            rd_ptr_next = '0;
            state_next  = FILL;
          end else begin
            rd_ptr_next = rd_ptr + AW'(1);
          end
        end
      end
      default: state_next = FILL;
    endcase
  end

  assign bus.out_valid  = (state == DRAIN);
  assign bus.busy       = (state == DRAIN);
  assign bus.out_pixel  = bus.out_valid ? mem[rd_ptr] : '0;
  assign bus.out_last   = bus.out_valid && (rd_ptr == LAST_PIX);
  assign bus.frame_done = frame_done_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_baw_frame_writer.sv
// Bench for baw_frame_writer with a 4x4 frame: scoreboard queue of expected
// pixels filled as pairs are driven, drained by a negedge monitor on handshakes.
module tb_baw_frame_writer;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  baw_frame_writer_if #(.width_RGB(8)) bus ();

  baw_frame_writer #(
    .width_RGB(8),
    .IMG_W    (4),
    .IMG_H    (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int fd_cnt      = 0;
  int total_hs    = 0;
  int hs_cnt      = 0;
  bit stall       = 1'b0;
  logic [7:0] held;
  logic [7:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard pops, hold-under-stall, out_last position, idle zeros.
  always @(negedge clk) begin
    if (rst) begin
      hs_cnt = 0;
      stall  = 1'b0;
    end else begin
      if (bus.frame_done) fd_cnt++;
      if (!bus.out_valid) begin
        check_val("pix_idle", bus.out_pixel, 0);
        check_val("last_idle", bus.out_last, 0);
      end else begin
        if (stall) check_val("hold", bus.out_pixel, held);
        check_val("last", bus.out_last, (hs_cnt == N - 1));
        if (bus.out_ready) begin
          stall = 1'b0;
          check_val("sb_avail", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) check_val("pixel", bus.out_pixel, exp_q.pop_front());
          hs_cnt++;
          total_hs++;
          if (hs_cnt == N) hs_cnt = 0;
        end else begin
          stall = 1'b1;
          held  = bus.out_pixel;
        end
      end
    end
  end

  task automatic fill_frame(input logic [7:0] base, input int gap);
    for (int k = 0; k < N / 2; k++) begin
      if (k == N / 2 - 1) check_val("no_early_done", fd_cnt, 0);
      bus.ready_signal  = 1'b1;
      bus.black_white_0 = base + 8'(2 * k);
      bus.black_white_x = base + 8'(2 * k + 1);
      exp_q.push_back(base + 8'(2 * k));
      exp_q.push_back(base + 8'(2 * k + 1));
      tick();
      if (gap > 0 && k != N / 2 - 1) begin
        bus.ready_signal = 1'b0;
        repeat (gap) tick();
      end
    end
    bus.ready_signal = 1'b0;
    check_val("frame_done", bus.frame_done, 1);
    check_val("valid_first", bus.out_valid, 1);
    check_val("busy_drain", bus.busy, 1);
  endtask

  // mode 0: out_ready held high; mode 1: out_ready 1,0,0,1 repeating.
  // ovf_cycles: number of leading drain cycles with an 0xFF/0xFF pair offered.
  task automatic drain(input int mode, input int ovf_cycles);
    int cyc = 0;
    while (bus.out_valid && cyc < 200) begin
      bus.out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (cyc < ovf_cycles) begin
        bus.ready_signal  = 1'b1;
        bus.black_white_0 = 8'hFF;
        bus.black_white_x = 8'hFF;
      end else begin
        bus.ready_signal = 1'b0;
      end
      tick();
      cyc++;
    end
    bus.ready_signal = 1'b0;
    check_val("drain_end", bus.out_valid, 0);
    if (mode == 0) check_val("drain_cycles", cyc, N);
    check_val("hs_total", total_hs, N);
    check_val("sb_empty", exp_q.size(), 0);
    check_val("fd_once", fd_cnt, 1);
    check_val("busy_fill", bus.busy, 0);
    total_hs = 0;
    fd_cnt   = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    bus.ready_signal  = 1'b0;
    bus.black_white_0 = '0;
    bus.black_white_x = '0;
    bus.out_ready     = 1'b0;

    // Reset with random inputs.
    rst = 1'b1;
    repeat (2) begin
      bus.ready_signal  = 1'($urandom);
      bus.black_white_0 = 8'($urandom);
      bus.black_white_x = 8'($urandom);
      bus.out_ready     = 1'($urandom);
      tick();
      check_val("rst_valid", bus.out_valid, 0);
      check_val("rst_pixel", bus.out_pixel, 0);
      check_val("rst_last", bus.out_last, 0);
      check_val("rst_done", bus.frame_done, 0);
      check_val("rst_busy", bus.busy, 0);
      check_val("rst_ovf", bus.overflow, 0);
    end
    rst = 1'b0;
    bus.ready_signal = 1'b0;
    bus.out_ready    = 1'b1;
    fd_cnt = 0;
    total_hs = 0;
    tick();

    // Back-to-back fill, full-rate drain.
    fill_frame(8'h00, 0);
    drain(0, 0);

    // Backpressure during drain.
    fill_frame(8'h40, 0);
    drain(1, 0);

    // Gappy input: a pair every third cycle.
    fill_frame(8'h00, 2);
    drain(0, 0);
    check_val("ovf_clear", bus.overflow, 0);

    // Pairs offered during drain are dropped and flag overflow.
    fill_frame(8'h20, 0);
    drain(0, 4);
    check_val("ovf_set", bus.overflow, 1);
    repeat (3) tick();
    check_val("ovf_sticky", bus.overflow, 1);

    // Reset mid-drain at rd_ptr=5.
    fill_frame(8'h60, 0);
    bus.out_ready = 1'b1;
    begin
      int cyc = 0;
      while (total_hs < 5 && cyc < 100) begin
        tick();
        cyc++;
      end
    end
    check_val("mid_hs", total_hs, 5);
    rst = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    check_val("mid_rst_valid", bus.out_valid, 0);
    check_val("mid_rst_ovf", bus.overflow, 0);
    check_val("mid_rst_busy", bus.busy, 0);
    rst = 1'b0;
    exp_q.delete();
    total_hs = 0;
    fd_cnt   = 0;
    bus.out_ready = 1'b1;
    tick();

    // Next frame must start at address 0.
    fill_frame(8'hA0, 0);
    drain(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
